ika_slotgen: RTL and testbench
==============================

IKA_SLOTGEN -- requirements
Module: ika_slotgen

Interface
REQ-001 SHALL have parameter SLOTS, default 32, meaning slots per frame; power of 2, 16..64; SW = log2(SLOTS).
REQ-002 SHALL have parameter CLKDIV, default 2, meaning phiM enables per phi1 period; even, 2..8.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning reset-release synchronizer depth, 2..4.
REQ-004 SHALL have parameter NUM_CH, default 2, meaning SH strobe count; 1, 2 or 4.
REQ-005 SHALL have parameter SH_DELAY, default 5, meaning SH pipeline depth in phi1 cycles, 1..8.
REQ-006 SHALL have parameter NUM_MARK, default 4, meaning programmable slot-decode outputs, 1..8.
REQ-007 SHALL have the following ports: i_EMUCLK  in  1  emulator master clock; all flops on its rising edge (one clock domain).
REQ-008 SHALL have the following port: i_IC_n  in  1  reset; asynchronous, active-low.
REQ-009 SHALL have the following ports: i_phiM_PCEN_n  in  1  phiM enable, active low; o_MRST_n  out  1  core reset, active low.
REQ-010 SHALL have the following ports: o_phi1  out  1  phi1 level; o_phi1_PCEN_n / o_phi1_NCEN_n  out  1 each  phi1 rising/falling enables, active low.
REQ-011 SHALL have the following ports: o_SLOT  out  SW  current slot; o_FRAME  out  1  frame strobe; o_FRAME_CNT  out  8  frame count.
REQ-012 SHALL have the following ports: i_MARK_SLOT  in  NUM_MARK*SW  mark k slot in bits [k*SW +: SW]; i_MARK_EN  in  NUM_MARK  per-mark enable; o_MARK  out  NUM_MARK  mark strobes; o_SH  out  NUM_CH  SH strobes.

Function
REQ-013 SHALL keep a divider div (0..CLKDIV-1) that advances on each cycle with i_phiM_PCEN_n=0 and wraps CLKDIV-1->0.
REQ-014 SHALL drive o_phi1=1 when div<CLKDIV/2, else 0.
REQ-015 SHALL drive o_phi1_NCEN_n low exactly when i_phiM_PCEN_n=0 and div=CLKDIV/2-1, and o_phi1_PCEN_n low exactly when i_phiM_PCEN_n=0 and div=CLKDIV-1; both are combinational and one EMUCLK wide.
REQ-016 SHALL shift i_IC_n into a SYNC_STAGES-deep chain on each phiM enable, and shall load the chain output into o_MRST_n on each phi1 NCEN.
REQ-017 SHALL hold the slot counter at 0 on an NCEN while o_MRST_n=0; otherwise it SHALL increment on each NCEN and wrap SLOTS-1->0; o_SLOT is the counter.
REQ-018 SHALL register o_MARK[k] on NCEN as i_MARK_EN[k] AND (counter == i_MARK_SLOT[k]), giving one phi1 of latency; mark inputs SHALL be sampled on that NCEN only, and a change mid-frame takes effect at the next NCEN.
REQ-019 SHALL register o_FRAME on NCEN as (counter==SLOTS-1) AND o_MRST_n, so it is high for one phi1 while o_SLOT=0.
REQ-020 SHALL increment o_FRAME_CNT on each NCEN where counter==SLOTS-1 and o_MRST_n=1, and shall wrap 255->0.
REQ-021 SHALL, with W=SLOTS/(2*NUM_CH), set raw_sh[k]=(counter/W == 2k+1).
REQ-022 SHALL delay raw_sh through SH_DELAY NCEN stages, and shall register o_SH[k] on NCEN as the last stage AND o_MRST_n, giving a total latency of SH_DELAY+1 phi1.
REQ-023 SHALL make all outputs, the divider and the SH pipeline hold their value on cycles without the relevant enable.

Reset
REQ-024 SHALL, while i_IC_n=0 (asynchronously), hold div=0, sync chain=0, o_MRST_n=0, counter=0, o_FRAME=0, o_FRAME_CNT=0, o_MARK=0, o_SH=0 and the SH pipeline=0; o_phi1=1 and both phi1 enables high.
REQ-025 SHALL start the divider counting on the first phiM enable after i_IC_n rises; the core stays in reset until o_MRST_n rises per REQ-016.
REQ-026 SHALL, if i_IC_n drops mid-frame, clear all state immediately with no partial strobe, and the next frame starts at slot 0 with o_FRAME_CNT=0.

Verification
REQ-027 SHALL cover: defaults, phiM enable every 4 EMUCLK, i_IC_n released -> o_MRST_n rises at the 2nd NCEN after release, and o_SLOT first reads 1 one phi1 later.
REQ-028 SHALL cover: defaults, 64 phi1 after reset -> o_FRAME pulses twice while o_SLOT=0 and o_FRAME_CNT=2; at 256 frames o_FRAME_CNT wraps to 0.
REQ-029 SHALL cover: defaults -> o_SH[0] high for 8 phi1 starting when o_SLOT=14, and o_SH[1] high starting when o_SLOT=30.
REQ-030 SHALL cover: i_MARK_SLOT[0]=11, i_MARK_EN=1 -> o_MARK[0] high exactly while o_SLOT=12, once per frame; with i_MARK_EN=0 -> never high.
REQ-031 SHALL cover: CLKDIV=4, SLOTS=16, NUM_CH=4 -> o_phi1 high 2 / low 2 phiM enables, and o_SH[k] windows 2 phi1 wide at counter 2,6,10,14 (+6 latency).
REQ-032 SHALL cover: i_IC_n pulsed low for 1 EMUCLK at slot 20 -> all outputs clear in the same cycle, and restart per REQ-027.

Source files
------------

// File: rtl/ika_slotgen.sv
// rtl/ika_slotgen.sv - phi1 clock-enable generator, reset synchronizer and slot/frame sequencer
// Slot counter advances on phi1 falling enables; SH strobes and marks decode from it.
module ika_slotgen #(
   parameter  int SLOTS       = 32,
   parameter  int CLKDIV      = 2,
   parameter  int SYNC_STAGES = 2,
   parameter  int NUM_CH      = 2,
   parameter  int SH_DELAY    = 5,
   parameter  int NUM_MARK    = 4,
   localparam int SW          = $clog2(SLOTS)
) (
   input  logic                   i_EMUCLK,
   input  logic                   i_IC_n,
   input  logic                   i_phiM_PCEN_n,
   output logic                   o_MRST_n,
   output logic                   o_phi1,
   output logic                   o_phi1_PCEN_n,
   output logic                   o_phi1_NCEN_n,
   output logic [SW-1:0]          o_SLOT,
   output logic                   o_FRAME,
   output logic [7:0]             o_FRAME_CNT,
   input  logic [NUM_MARK*SW-1:0] i_MARK_SLOT,
   input  logic [NUM_MARK-1:0]    i_MARK_EN,
   output logic [NUM_MARK-1:0]    o_MARK,
   output logic [NUM_CH-1:0]      o_SH
);

   localparam int DW   = $clog2(CLKDIV);
   localparam int HALF = CLKDIV / 2;
   localparam int W    = SLOTS / (2 * NUM_CH);

   logic [DW-1:0]          r_div;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_mrst;
   logic [SW-1:0]          r_slot;
   logic                   r_frame;
   logic [7:0]             r_frame_cnt;
   logic [NUM_MARK-1:0]    r_mark;
   logic [NUM_CH-1:0]      r_sh;
   logic [NUM_CH-1:0]      r_shp [SH_DELAY];

   logic                   w_pcen;
   logic                   w_ncen;
   logic                   w_phi1_rise;
   logic                   w_last;
   logic [SW-1:0]          w_grp;
   logic [NUM_CH-1:0]      w_raw_sh;
   logic [NUM_MARK-1:0]    w_mark_hit;

   // Gating with i_IC_n keeps both phi1 enables inactive while reset is held.
   assign w_pcen      = ~i_phiM_PCEN_n & i_IC_n;
   assign w_ncen      = w_pcen & (r_div == DW'(HALF - 1));
   assign w_phi1_rise = w_pcen & (r_div == DW'(CLKDIV - 1));
   assign w_last      = (r_slot == SW'(SLOTS - 1)) & r_mrst;
   assign w_grp       = r_slot / SW'(W);

   genvar gk;
   generate
      for (gk = 0; gk < NUM_CH; gk++) begin : g_raw_sh
         assign w_raw_sh[gk] = (w_grp == SW'(2 * gk + 1));
      end
      for (gk = 0; gk < NUM_MARK; gk++) begin : g_mark
         assign w_mark_hit[gk] = i_MARK_EN[gk] & (r_slot == i_MARK_SLOT[gk*SW +: SW]);
      end
   endgenerate

   always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
      if (!i_IC_n) begin
         r_div  <= '0;
         r_sync <= '0;
      end else if (w_pcen) begin
         r_div  <= (r_div == DW'(CLKDIV - 1)) ? '0 : r_div + DW'(1);
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_IC_n};
      end
   end

   always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
      if (!i_IC_n) begin
         r_mrst      <= 1'b0;
         r_slot      <= '0;
         r_frame     <= 1'b0;
         r_frame_cnt <= '0;
         r_mark      <= '0;
         r_sh        <= '0;
         for (int i = 0; i < SH_DELAY; i++) r_shp[i] <= '0;
      end else if (w_ncen) begin
         r_mrst  <= r_sync[SYNC_STAGES-1];
         r_slot  <= r_mrst ? r_slot + SW'(1) : '0;
         r_frame <= w_last;
         r_mark  <= w_mark_hit;
         if (w_last) r_frame_cnt <= r_frame_cnt + 8'd1;
         r_shp[0] <= w_raw_sh;
         for (int i = 1; i < SH_DELAY; i++) r_shp[i] <= r_shp[i-1];
         r_sh <= r_shp[SH_DELAY-1] & {NUM_CH{r_mrst}};
      end
   end

   assign o_phi1        = (r_div < DW'(HALF));
   assign o_phi1_NCEN_n = ~w_ncen;
   assign o_phi1_PCEN_n = ~w_phi1_rise;
   assign o_MRST_n      = r_mrst;
   assign o_SLOT        = r_slot;
   assign o_FRAME       = r_frame;
   assign o_FRAME_CNT   = r_frame_cnt;
   assign o_MARK        = r_mark;
   assign o_SH          = r_sh;

endmodule

// File: tb/tb_ika_slotgen.sv
// tb/tb_ika_slotgen.sv - directed bench for ika_slotgen (default and CLKDIV=4/SLOTS=16/NUM_CH=4 builds)
module tb_ika_slotgen;

   logic        clk = 1'b0;
   logic        ic_n;
   logic        pcen_n;
   logic [19:0] mslot;
   logic [3:0]  men;
   logic        mrst, phi1, p1p_n, p1n_n, frame;
   logic [4:0]  slot;
   logic [7:0]  fcnt;
   logic [3:0]  mark;
   logic [1:0]  sh;

   logic [15:0] mslot4;
   logic [3:0]  men4;
   logic        mrst4, phi14, p1p4_n, p1n4_n, frame4;
   logic [3:0]  slot4;
   logic [7:0]  fcnt4;
   logic [3:0]  mark4;
   logic [3:0]  sh4;

   int checks = 0;
   int errors = 0;
   int gap = 3;
   int es, f, es4, f4;

   always #5 clk = ~clk;

   ika_slotgen u_dut (
      .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phiM_PCEN_n(pcen_n), .o_MRST_n(mrst),
      .o_phi1(phi1), .o_phi1_PCEN_n(p1p_n), .o_phi1_NCEN_n(p1n_n), .o_SLOT(slot),
      .o_FRAME(frame), .o_FRAME_CNT(fcnt), .i_MARK_SLOT(mslot), .i_MARK_EN(men),
      .o_MARK(mark), .o_SH(sh)
   );

   ika_slotgen #(.SLOTS(16), .CLKDIV(4), .NUM_CH(4)) u_dut4 (
      .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phiM_PCEN_n(pcen_n), .o_MRST_n(mrst4),
      .o_phi1(phi14), .o_phi1_PCEN_n(p1p4_n), .o_phi1_NCEN_n(p1n4_n), .o_SLOT(slot4),
      .o_FRAME(frame4), .o_FRAME_CNT(fcnt4), .i_MARK_SLOT(mslot4), .i_MARK_EN(men4),
      .o_MARK(mark4), .o_SH(sh4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One phiM enable: low for one EMUCLK, then gap idle cycles.
   task automatic pm();
      pcen_n = 1'b0;
      @(posedge clk); #1;
      pcen_n = 1'b1;
      if (gap > 0) begin
         repeat (gap) @(posedge clk);
         #1;
      end
   endtask

   task automatic step_def();
      pm();
      pm();
      es = (es + 1) % 32;
      if (es == 0) f++;
   endtask

   task automatic check_def(input string tag);
      chk({tag, ".mrst"},  mrst, 1);
      chk({tag, ".slot"},  slot, es);
      chk({tag, ".frame"}, frame, (es == 0));
      chk({tag, ".fcnt"},  fcnt, f % 256);
      chk({tag, ".mark"},  mark, {2'b00, (es == 0), (men[0] && es == 12)});
      chk({tag, ".sh"},    sh, {((es >= 30) || (es <= 5 && f > 0)), (es >= 14 && es <= 21)});
   endtask

   // Release sequence for the default build: MRST rises on the 2nd NCEN, slot reads 1 one phi1 later.
   task automatic release_seq(input string tag);
      pcen_n = 1'b0; #1;
      chk({tag, ".e1_ncen_n"}, p1n_n, 0);
      chk({tag, ".e1_pcen_n"}, p1p_n, 1);
      pm();
      chk({tag, ".e1_phi1"}, phi1, 0);
      chk({tag, ".e1_mrst"}, mrst, 0);
      pcen_n = 1'b0; #1;
      chk({tag, ".e2_pcen_n"}, p1p_n, 0);
      chk({tag, ".e2_ncen_n"}, p1n_n, 1);
      pm();
      chk({tag, ".e2_phi1"}, phi1, 1);
      chk({tag, ".e2_mrst"}, mrst, 0);
      pm();
      chk({tag, ".e3_mrst"}, mrst, 1);
      chk({tag, ".e3_slot"}, slot, 0);
      pm();
      pm();
      chk({tag, ".e5_slot"}, slot, 1);
      chk({tag, ".e5_fcnt"}, fcnt, 0);
      es = 1;
      f  = 0;
   endtask

   initial begin
      ic_n   = 1'b0;
      pcen_n = 1'b1;
      mslot  = {5'd0, 5'd5, 5'd31, 5'd11};
      men    = 4'b0011;
      mslot4 = '0;
      men4   = '0;
      repeat (3) @(posedge clk);
      #1;

      chk("rst.mrst", mrst, 0);
      chk("rst.slot", slot, 0);
      chk("rst.frame", frame, 0);
      chk("rst.fcnt", fcnt, 0);
      chk("rst.mark", mark, 0);
      chk("rst.sh", sh, 0);
      chk("rst.phi1", phi1, 1);
      pcen_n = 1'b0; #1;
      chk("rst.ncen_n", p1n_n, 1);
      chk("rst.pcen_n", p1p_n, 1);
      pm();
      chk("rst.phi1_hold", phi1, 1);
      chk("rst4.phi1", phi14, 1);

      ic_n = 1'b1;
      release_seq("rel");

      for (int i = 0; i < 100; i++) begin
         if (es == 20 && f == 1) men[0] = 1'b0;
         else if (es == 20 && f == 2) men[0] = 1'b1;
         step_def();
         check_def("run");
      end

      gap = 0;
      while (!(f == 257 && es == 20)) begin
         step_def();
         if ((f == 255 && es == 31) || (f == 256 && es <= 1) || (f == 257 && es == 20))
            check_def("wrap");
      end

      ic_n = 1'b0; #1;
      chk("pulse.mrst", mrst, 0);
      chk("pulse.slot", slot, 0);
      chk("pulse.fcnt", fcnt, 0);
      chk("pulse.sh", sh, 0);
      chk("pulse.mark", mark, 0);
      chk("pulse.frame", frame, 0);
      chk("pulse.phi1", phi1, 1);
      @(posedge clk); #1;
      ic_n = 1'b1;
      gap = 3;
      release_seq("restart");
      for (int i = 0; i < 40; i++) begin
         step_def();
         check_def("post");
      end

      ic_n = 1'b0;
      @(posedge clk); #1;
      chk("d4rst.mrst", mrst4, 0);
      chk("d4rst.slot", slot4, 0);
      chk("d4rst.sh", sh4, 0);
      chk("d4rst.phi1", phi14, 1);
      ic_n = 1'b1;
      pm();
      chk("d4.e1_phi1", phi14, 1);
      pcen_n = 1'b0; #1;
      chk("d4.e2_ncen_n", p1n4_n, 0);
      chk("d4.e2_pcen_n", p1p4_n, 1);
      pm();
      chk("d4.e2_phi1", phi14, 0);
      pm();
      chk("d4.e3_phi1", phi14, 0);
      pcen_n = 1'b0; #1;
      chk("d4.e4_pcen_n", p1p4_n, 0);
      chk("d4.e4_ncen_n", p1n4_n, 1);
      pm();
      chk("d4.e4_phi1", phi14, 1);
      repeat (6) pm();
      chk("d4.e10_slot", slot4, 1);
      chk("d4.e10_mrst", mrst4, 1);
      es4 = 1;
      f4  = 0;
      for (int i = 0; i < 40; i++) begin
         repeat (4) pm();
         es4 = (es4 + 1) % 16;
         if (es4 == 0) f4++;
         chk("d4.slot", slot4, es4);
         chk("d4.sh", sh4, {((es4 == 4 || es4 == 5) && f4 > 0),
                             ((es4 == 0 || es4 == 1) && f4 > 0),
                             (es4 == 12 || es4 == 13),
                             (es4 == 8 || es4 == 9)});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
